// File: rtl/sram_lane_pkg.sv
// Shared types and constants for the external SRAM lane model.
package sram_lane_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline: RD_LAT stages of {valid, lane mask, data}, flushed to invalid on reset.
module sram_rd_pipe
    import sram_lane_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 2,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [LANES-1:0]  in_mask,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [LANES-1:0]  out_mask,
    output logic [DATA_W-1:0] out_data
);

    localparam int W = 1 + LANES + DATA_W;

    logic [W-1:0] stage_q [RD_LAT];
    logic [W-1:0] stage_d [RD_LAT];

    always_comb begin
        stage_d[0] = {in_valid, in_mask, in_data};
        for (int i = 1; i < RD_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign {out_valid, out_mask, out_data} = stage_q[RD_LAT-1];

endmodule

// File: rtl/sram_lane_model.sv
// Behavioural model of the board's asynchronous-bus SRAM: byte-lane writes, pipelined
// reads, tri-state data bus, post-reset clear sweep and out-of-range flagging.
module sram_lane_model
    import sram_lane_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 18,
    parameter int DEPTH        = 64,
    parameter int RD_LAT       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                clk,
    input  logic                rst,
    inout  wire  [DATA_W-1:0]   SRAM_DQ,
    input  logic [ADDR_W-1:0]   SRAM_ADDR,
    input  logic [DATA_W/8-1:0] SRAM_BE_N,
    input  logic                SRAM_WE_N,
    input  logic                SRAM_CE_N,
    input  logic                SRAM_OE_N,
    output logic                init_done,
    output logic                addr_err
);

    localparam int L       = lanes(DATA_W);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ADDR_P1 = ADDR_W + 1;
    localparam logic [ADDR_W:0]  DEPTH_A  = ADDR_P1'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    // Latency outside the supported range is clamped rather than producing a broken pipe.
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic              addr_err_q, addr_err_d;

    logic              ready, access, in_range, wr_en, rd_en, clr_en;
    logic [PTR_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;
    logic              pipe_valid;
    logic [L-1:0]      pipe_mask;
    logic [DATA_W-1:0] pipe_data;
    logic [L-1:0]      lane_oe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RST != 0) ? ST_INIT : ST_READY;
            clr_ptr_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_INIT) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_PTR) begin
                state_d   = ST_READY;
                clr_ptr_d = '0;
            end
        end
    end

    always_comb begin
        ready      = (state_q == ST_READY) && !rst;
        access     = ready && !SRAM_CE_N;
        in_range   = {1'b0, SRAM_ADDR} < DEPTH_A;
        wr_en      = access && !SRAM_WE_N && in_range;
        rd_en      = access && SRAM_WE_N;
        clr_en     = (state_q == ST_INIT) && !rst;
        addr_err_d = access && !in_range;
    end

    assign init_done = ready;
    assign addr_err  = addr_err_q;
    assign idx       = SRAM_ADDR[PTR_W-1:0];
    assign rd_word   = in_range ? mem[idx] : '0;

    // Clear sweep owns the array while in INIT; bus writes only land once READY.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < L; b++) begin
                if (!SRAM_BE_N[b]) begin
                    mem[idx][8*b +: 8] <= SRAM_DQ[8*b +: 8];
                end
            end
        end
    end

    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .LANES  (L),
        .RD_LAT (LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en),
        .in_mask   (~SRAM_BE_N),
        .in_data   (rd_word),
        .out_valid (pipe_valid),
        .out_mask  (pipe_mask),
        .out_data  (pipe_data)
    );

    // Bus gating is combinational so the model lets go the moment the writer takes WE_N low.
    for (genvar gi = 0; gi < L; gi++) begin : g_lane
        assign lane_oe[gi] = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N && pipe_valid && pipe_mask[gi];
        assign SRAM_DQ[8*gi +: 8] = lane_oe[gi] ? pipe_data[8*gi +: 8] : 8'bz;
    end

endmodule

// File: doc/sram_lane_model.md
# sram_lane_model

Parametrised behavioural model of the board's external asynchronous-bus SRAM, used as the memory endpoint in processor/SRAM-controller simulations. Generalises data width, depth and byte-lane count, and adds per-lane write masking, CE/OE gating, configurable read latency, a counted post-reset clear sweep and out-of-range address flagging. It sits on the same SRAM_* pin bundle the SRAM controller drives.

## Interface
Parameters:
- DATA_W, 16, data bus width; multiple of 8; lanes L = DATA_W/8
- ADDR_W, 18, address bus width
- DEPTH, 64, implemented words; DEPTH ≤ 2^ADDR_W
- RD_LAT, 1, read pipeline depth in clk cycles, legal 1..4
- CLEAR_ON_RST, 1, 1 = run clear sweep after reset; 0 = contents retained, READY immediately

Ports (single clock `clk`; reset `rst` is asynchronous, active-high):
- clk  in  1  model clock
- rst  in  1  async active-high reset
- SRAM_DQ  inout  DATA_W  bidirectional data bus
- SRAM_ADDR  in  ADDR_W  word address
- SRAM_BE_N  in  L  active-low byte-lane enables; bit b covers DQ[8b+7:8b] (L=2: bit1=UB, bit0=LB)
- SRAM_WE_N  in  1  active-low write enable
- SRAM_CE_N  in  1  active-low chip enable
- SRAM_OE_N  in  1  active-low output enable
- init_done  out  1  high once clear sweep complete
- addr_err  out  1  one-cycle pulse on access with SRAM_ADDR ≥ DEPTH

## Operation
- States: INIT, READY. rst → INIT (CLEAR_ON_RST=1) or READY (CLEAR_ON_RST=0).
- INIT: counter clr_ptr from 0; each clk writes 0 to memory[clr_ptr], increments; after writing DEPTH-1 → READY. Exactly DEPTH cycles. Bus accesses ignored, DQ = Z, addr_err stays 0.
- READY: init_done=1; stays until rst.
- Access = CE_N=0 at posedge clk, in READY.
- Write (access, WE_N=0): addr<DEPTH → for each lane b with BE_N[b]=0, memory[addr] lane b ← DQ lane b; other lanes unchanged. BE_N all 1 → no change.
- Read (access, WE_N=1): memory[addr] sampled at that edge into stage 0 of read pipe with valid=1 and lane mask ~BE_N; non-access edges push valid=0.
- DQ drive: lane b driven with pipe-output data iff CE_N=0, OE_N=0, WE_N=1, pipe-output valid=1, pipe-output mask bit b=1; else lane b = Z. DQ gating on CE/OE/WE is combinational.
- Out-of-range (addr ≥ DEPTH): write discarded; read returns 0; addr_err=1 for the cycle after that edge.
- Read sees memory as of its sampling edge; a later write to same address does not alter an in-flight read.

## Timing
- Reset values: init_done=0, addr_err=0, read pipe all invalid, DQ = Z, clr_ptr=0. Memory contents not touched by rst itself.
- rst mid-sweep or mid-read: pipe flushed, sweep restarts at 0 after rst falls.
- Read latency: sampled at edge n → data on DQ after edge n+RD_LAT-1 (RD_LAT=1: right after sampling edge), held until next pipe advance.
- Write at edge n, read of same address at edge n+1 → new data.
- Back-to-back reads every cycle: one word per cycle, no bubbles.
- WE_N falling → DQ released same cycle (no contention with writer).
- init_done rises after edge DEPTH following rst release.

## Structure
- Package sram_lane_pkg: state enum {INIT, READY}, function lanes(DATA_W), RD_LAT bound constants.
- Sub-module sram_rd_pipe: RD_LAT-stage shift register of {valid, mask[L], data[DATA_W]}, async reset to invalid.
- Top holds memory array, clr_ptr counter/FSM, write-lane logic, tri-state drivers.

## Test plan
- Reset, DEPTH=64: init_done low for 64 cycles then high; a write attempted during INIT is lost; all 64 words read 0x0000.
- Write 0xA5C3 to addr 5 (BE_N=00), then BE_N=10 write 0x00FF → read addr 5 returns 0xA5FF; read with BE_N=01 drives upper byte 0xA5, lower Z.
- RD_LAT=3: reads of addrs 1,2,3 on consecutive edges after writes 0x11,0x22,0x33 → DQ 0x11,0x22,0x33 after edges n+2,n+3,n+4.
- OE_N=1 or CE_N=1 while pipe valid → DQ = Z; restoring OE_N=0 shows held data.
- Write addr 64 (DEPTH=64) → addr_err pulse one cycle, memory unchanged; read addr 64 → 0x0000 plus pulse.
- Assert rst mid-sweep at clr_ptr=30 and during a RD_LAT=2 read → DQ Z immediately, sweep restarts, init_done after 64 more cycles.
